fifo_stream_reader: RTL and testbench

Drain side of the team's synchronous FIFO. Issues `fifo_rd_en` against the FIFO's `empty` flag, captures the FIFO's one-cycle-latency registered read data, and re-presents it as a valid/ready stream. It sits between a FIFO instance and any downstream consumer that may stall. It never loses, duplicates or reorders a word, and it sustains one word per cycle when the consumer is always ready.

---
 rtl/fifo_rd_pkg.sv | 13 +
 rtl/fifo_stream_reader_if.sv | 15 +
 rtl/fifo_rd_buf.sv | 42 ++++
 rtl/fifo_stream_reader.sv | 56 +++++
 tb/tb_fifo_stream_reader.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO drain-side stream reader.
package fifo_rd_pkg;
  localparam int FIFO_RD_BUF_DEPTH = 3;
  localparam int FIFO_RD_CNT_W     = 16;

  typedef logic [1:0] fifo_rd_occ_t;
  typedef logic [1:0] fifo_rd_ptr_t;

  // Circular pointer advance over the 3-entry buffer (2 wraps to 0).
  function automatic fifo_rd_ptr_t ptr_inc(input fifo_rd_ptr_t p);
    return (p == fifo_rd_ptr_t'(FIFO_RD_BUF_DEPTH - 1)) ? '0 : p + 2'd1;
  endfunction
endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus downstream valid/ready stream, bundled.
// master: the reader side; slave: the FIFO + consumer environment.
interface fifo_stream_reader_if #(parameter int WIDTH = 8);
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (input fifo_empty, fifo_data, m_ready,
                  output fifo_rd_en, m_valid, m_data);
  modport slave  (output fifo_empty, fifo_data, m_ready,
                  input fifo_rd_en, m_valid, m_data);
endinterface

// File: rtl/fifo_rd_buf.sv
// 3-entry circular skid buffer: tail write on push, head advance on pop,
// occupancy tracked explicitly. clr empties it without touching storage.
module fifo_rd_buf
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clr,
  output logic [WIDTH-1:0] head_data,
  output fifo_rd_occ_t     occ
);
  logic [FIFO_RD_BUF_DEPTH-1:0][WIDTH-1:0] mem;
  fifo_rd_ptr_t head, tail;

  // Storage, pointers and occupancy; reset zeroes storage so head_data reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem  <= '0;
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (clr) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
      occ <= occ + fifo_rd_occ_t'(push) - fifo_rd_occ_t'(pop);
    end
  end

  assign head_data = mem[head];
endmodule

// File: rtl/fifo_stream_reader.sv
// Drain side of the synchronous FIFO: issues reads against empty, captures the
// one-cycle-latency read data and re-presents it as a valid/ready stream.
// Optional FIFO_RD_STATS_EN adds a saturating delivered-word counter.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  fifo_stream_reader_if.master     bus
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [FIFO_RD_CNT_W-1:0] xfer_count
`endif
);
  logic         pending;
  logic         capture;
  logic         pop;
  logic [2:0]   committed;
  fifo_rd_occ_t occ;

  // Words held plus word in flight; a read is only issued if a slot is free
  // for it, so capture can never hit a full buffer. No m_ready dependency.
  assign committed      = {1'b0, occ} + {2'b00, pending};
  assign bus.fifo_rd_en = rst_n && !flush && !bus.fifo_empty && (committed < 3'd3);
  assign capture        = pending && !flush;
  assign bus.m_valid    = (occ != '0);
  assign pop            = bus.m_valid && bus.m_ready && !flush;

  // Read-return tracker; fifo_rd_en is already low during flush, so this clears too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= 1'b0;
    else        pending <= bus.fifo_rd_en;
  end

  fifo_rd_buf #(.WIDTH(WIDTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (bus.fifo_data),
    .pop       (pop),
    .clr       (flush),
    .head_data (bus.m_data),
    .occ       (occ)
  );

`ifdef FIFO_RD_STATS_EN
  // Delivered-word counter, saturating; survives flush, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               xfer_count <= '0;
    else if (pop && (xfer_count != '1))       xfer_count <= xfer_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural 16-deep FIFO
// (registered read data) and an in-order scoreboard on delivered beats.
module tb_fifo_stream_reader;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.WIDTH(WIDTH)) bus ();
`ifdef FIFO_RD_STATS_EN
  logic [15:0] xfer_count;
`endif

  fifo_stream_reader #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
`ifdef FIFO_RD_STATS_EN
    ,
    .xfer_count (xfer_count)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Behavioural FIFO, DEPTH 16, read data registered one cycle after rd_en.
  logic [7:0] fmem [16];
  int         wp = 0, rp = 0, fcnt = 0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       fclr = 1'b0;
  int         rd_pulses = 0;
  logic [7:0] rd_q [$];

  assign bus.fifo_empty = (fcnt == 0);

  always @(posedge clk) begin
    if (fclr) begin
      wp <= 0; rp <= 0; fcnt <= 0;
    end else begin
      if (bus.fifo_rd_en) begin
        bus.fifo_data <= fmem[rp];
        rd_q.push_back(fmem[rp]);
        rp <= (rp + 1) % 16;
        rd_pulses++;
      end
      if (wr_en && fcnt < 16) begin
        fmem[wp] <= wr_data;
        wp <= (wp + 1) % 16;
      end
      fcnt <= fcnt + ((wr_en && fcnt < 16) ? 1 : 0) - (bus.fifo_rd_en ? 1 : 0);
    end
  end

  // Scoreboard: each beat must be the oldest word read out of the FIFO.
  int cyc = 0, beats = 0, first_cyc = -1, last_cyc = -1;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("occ_inv", {31'd0, (int'(dut.occ) + int'(dut.pending)) <= 3}, 32'd1);
      if (flush) rd_q.delete();
      else if (bus.m_valid && bus.m_ready) begin
        if (rd_q.size() == 0) chk("beat_extra", {24'd0, bus.m_data}, 32'hFFFF_FFFF);
        else chk("beat", {24'd0, bus.m_data}, {24'd0, rd_q.pop_front()});
        beats++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d; tick(); wr_en = 1'b0;
  endtask

  task automatic wait_beats(input int target, input int budget, input string tag);
    int n = 0;
    while (beats < target && n < budget) begin tick(); n++; end
    chk(tag, beats, target);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n = 0;
    while (!bus.m_valid && n < budget) begin tick(); n++; end
    chk(tag, {31'd0, bus.m_valid}, 32'd1);
  endtask

  initial begin
    bus.m_ready = 1'b0;
    fclr = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_valid", {31'd0, bus.m_valid}, 0);
    chk("rst_rd_en", {31'd0, bus.fifo_rd_en}, 0);
    chk("rst_data", {24'd0, bus.m_data}, 0);
    tick();
    rst_n = 1'b1; fclr = 1'b0;
    tick(); tick();

    // 1: 0x01..0x10 streamed with consumer always ready.
    bus.m_ready = 1'b1;
    beats = 0; first_cyc = -1;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i + 1);
      @(negedge clk);
      if (i == 1) chk("lat_c1", {31'd0, bus.m_valid}, 0);
      if (i == 2) chk("lat_c2", {31'd0, bus.m_valid}, 0);
      if (i == 3) begin
        chk("lat_c3", {31'd0, bus.m_valid}, 1);
        chk("lat_data", {24'd0, bus.m_data}, 32'h01);
      end
      tick();
    end
    wr_en = 1'b0;
    wait_beats(16, 40, "t1_beats");
    chk("t1_nogap", last_cyc - first_cyc, 15);
    repeat (3) tick();

    // 2: stalled consumer holds exactly three words.
    bus.m_ready = 1'b0;
    rd_pulses = 0; beats = 0;
    for (int i = 0; i < 8; i++) write_word(8'hA0 + 8'(i));
    repeat (6) tick();
    chk("t2_rd_pulses", rd_pulses, 3);
    chk("t2_fifo_left", fcnt, 5);
    chk("t2_hold_data", {24'd0, bus.m_data}, 32'hA0);
    chk("t2_hold_valid", {31'd0, bus.m_valid}, 1);
    repeat (3) tick();
    chk("t2_hold_again", {24'd0, bus.m_data}, 32'hA0);
    bus.m_ready = 1'b1;
    wait_beats(8, 40, "t2_beats");
    chk("t2_drained", rd_q.size(), 0);

    // 3: 200 words under a random consumer.
    beats = 0;
    begin
      int wr = 0, n = 0;
      while ((wr < 200 || beats < 200) && n < 3000) begin
        bus.m_ready = 1'($urandom_range(0, 1));
        wr_en = (wr < 200) && (fcnt < 16);
        wr_data = 8'(wr);
        if (wr_en) wr++;
        tick(); n++;
      end
      wr_en = 1'b0;
    end
    bus.m_ready = 1'b1;
    wait_beats(200, 40, "t3_beats");
    repeat (3) tick();
    chk("t3_drained", rd_q.size(), 0);

    // 4: flush while occ=2, pending=1.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) write_word(8'hB0 + 8'(i));
    repeat (6) tick();
    bus.m_ready = 1'b1;   // pop B0; no read since buffer is full
    tick();
    bus.m_ready = 1'b0;   // read of B3 issued here
    tick();
    chk("fl_setup", {29'd0, dut.occ, dut.pending}, 32'b101);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_valid", {31'd0, bus.m_valid}, 0);
    wait_valid(10, "fl_resume");
    chk("fl_next", {24'd0, bus.m_data}, 32'hB4);
    bus.m_ready = 1'b1;
    repeat (6) tick();
    chk("fl_drained", fcnt, 0);

    // 5: reset mid-stream with a full buffer.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) write_word(8'hC0 + 8'(i));
    repeat (6) tick();
    chk("rs_setup", {30'd0, dut.occ}, 3);
    rst_n = 1'b0; fclr = 1'b1;
    #1;
    chk("rs_valid", {31'd0, bus.m_valid}, 0);
    chk("rs_rd_en", {31'd0, bus.fifo_rd_en}, 0);
    chk("rs_data", {24'd0, bus.m_data}, 0);
    rd_q.delete();
    tick(); tick();
    rst_n = 1'b1; fclr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rs_quiet", {31'd0, bus.m_valid}, 0);
    end
    tick();
    write_word(8'hD0);
    wait_valid(10, "rs_resume");
    chk("rs_word", {24'd0, bus.m_data}, 32'hD0);
    bus.m_ready = 1'b1;
    repeat (3) tick();

`ifdef FIFO_RD_STATS_EN
    // Stats: saturation after 70000 delivered words, flush-immune.
    chk("st_small", xfer_count, 1);
    beats = 0;
    bus.m_ready = 1'b1;
    begin
      int wr = 0, n = 0;
      while (wr < 70000 && n < 72000) begin
        wr_en = (fcnt < 16);
        wr_data = 8'(wr);
        if (wr_en) wr++;
        tick(); n++;
      end
      wr_en = 1'b0;
    end
    wait_beats(70000, 40, "st_beats");
    chk("st_sat", xfer_count, 32'hFFFF);
    flush = 1'b1; tick(); flush = 1'b0; tick();
    chk("st_flush", xfer_count, 32'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
